// File: rtl/decode_issue_if.sv
// IF/ID -> ID -> ID/EX connection bundle for the decode/issue stage.
// The slave side is the ID stage; the master side drives IF/ID, regfile data and EX handshake.
interface decode_issue_if;
   localparam int unsigned XLEN = 32;

   logic            if_valid;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
   logic            id_ready;
   logic [4:0]      rf_addra;
   logic [4:0]      rf_addrb;
   logic [XLEN-1:0] rf_dataa;
   logic [XLEN-1:0] rf_datab;
   logic            ex_ready;
   logic            flush;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_rs1_data;
   logic [XLEN-1:0] ex_rs2_data;
   logic [XLEN-1:0] ex_imm;
   logic [4:0]      ex_rs1;
   logic [4:0]      ex_rs2;
   logic [4:0]      ex_rd;
   logic [6:0]      ex_opcode;
   logic [2:0]      ex_funct3;
   logic            ex_funct7b5;
   logic            ex_reg_write;
   logic            ex_mem_read;
   logic            ex_mem_write;
   logic            ex_illegal;

   modport slave (
      input  if_valid, if_instr, if_pc, rf_dataa, rf_datab, ex_ready, flush,
      output id_ready, rf_addra, rf_addrb, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
             ex_imm, ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal
   );

   modport master (
      output if_valid, if_instr, if_pc, rf_dataa, rf_datab, ex_ready, flush,
      input  id_ready, rf_addra, rf_addrb, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
             ex_imm, ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal
   );
endinterface

// File: rtl/decode_issue.sv
// RV32I ID stage: decode, regfile address drive, load-use bubble insertion and
// the ID/EX pipeline register with EX backpressure and flush.
module decode_issue #(
   parameter int unsigned XLEN      = 32,
   parameter bit          HAZARD_EN = 1'b1
) (
   input logic           clk,
   input logic           rstb,
   decode_issue_if.slave bus
);
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            illegal;
   } ex_t;

   logic            ex_valid_q, ex_valid_d;
   ex_t             ex_q, ex_d;
   ex_t             dec_c;
   logic            uses_rs1_c, uses_rs2_c;
   logic            hazard_c, adv_c;
   logic [XLEN-1:0] instr;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign instr = bus.if_instr;
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   assign bus.rf_addra = instr[19:15];
   assign bus.rf_addrb = instr[24:20];

   // Opcode decode into the ID/EX payload.
   always_comb begin
      dec_c          = '0;
      uses_rs1_c     = 1'b0;
      uses_rs2_c     = 1'b0;
      dec_c.pc       = bus.if_pc;
      dec_c.rs1_data = bus.rf_dataa;
      dec_c.rs2_data = bus.rf_datab;
      dec_c.rs1      = instr[19:15];
      dec_c.rs2      = instr[24:20];
      dec_c.rd       = instr[11:7];
      dec_c.opcode   = instr[6:0];
      dec_c.funct3   = instr[14:12];
      dec_c.funct7b5 = instr[30];
      case (instr[6:0])
         OPC_LUI, OPC_AUIPC: begin
            dec_c.imm       = imm_u;
            dec_c.reg_write = 1'b1;
         end
         OPC_JAL: begin
            dec_c.imm       = imm_j;
            dec_c.reg_write = 1'b1;
         end
         OPC_JALR, OPC_OPIMM: begin
            dec_c.imm       = imm_i;
            dec_c.reg_write = 1'b1;
            uses_rs1_c      = 1'b1;
         end
         OPC_BRANCH: begin
            dec_c.imm  = imm_b;
            uses_rs1_c = 1'b1;
            uses_rs2_c = 1'b1;
         end
         OPC_LOAD: begin
            dec_c.imm       = imm_i;
            dec_c.reg_write = 1'b1;
            dec_c.mem_read  = 1'b1;
            uses_rs1_c      = 1'b1;
         end
         OPC_STORE: begin
            dec_c.imm       = imm_s;
            dec_c.mem_write = 1'b1;
            uses_rs1_c      = 1'b1;
            uses_rs2_c      = 1'b1;
         end
         OPC_OP: begin
            dec_c.reg_write = 1'b1;
            uses_rs1_c      = 1'b1;
            uses_rs2_c      = 1'b1;
         end
         OPC_SYSTEM: ;
         default: dec_c.illegal = 1'b1;
      endcase
      if (dec_c.rd == 5'd0) dec_c.reg_write = 1'b0;
   end

   assign hazard_c = HAZARD_EN & bus.if_valid & ex_valid_q & ex_q.mem_read & (ex_q.rd != 5'd0) &
                     ((uses_rs1_c & (ex_q.rd == dec_c.rs1)) | (uses_rs2_c & (ex_q.rd == dec_c.rs2)));
   assign adv_c    = ~ex_valid_q | bus.ex_ready;
   assign bus.id_ready = bus.flush | (adv_c & ~hazard_c);

   // ID/EX next state: flush beats bubble beats load; fields hold unless loaded.
   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_d       = ex_q;
      if (bus.flush) begin
         ex_valid_d = 1'b0;
      end else if (adv_c) begin
         if (hazard_c) begin
            ex_valid_d = 1'b0;
         end else if (bus.if_valid) begin
            ex_valid_d = 1'b1;
            ex_d       = dec_c;
         end else begin
            ex_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_q       <= ex_d;
      end
   end

   assign bus.ex_valid     = ex_valid_q;
   assign bus.ex_pc        = ex_q.pc;
   assign bus.ex_rs1_data  = ex_q.rs1_data;
   assign bus.ex_rs2_data  = ex_q.rs2_data;
   assign bus.ex_imm       = ex_q.imm;
   assign bus.ex_rs1       = ex_q.rs1;
   assign bus.ex_rs2       = ex_q.rs2;
   assign bus.ex_rd        = ex_q.rd;
   assign bus.ex_opcode    = ex_q.opcode;
   assign bus.ex_funct3    = ex_q.funct3;
   assign bus.ex_funct7b5  = ex_q.funct7b5;
   assign bus.ex_reg_write = ex_q.reg_write;
   assign bus.ex_mem_read  = ex_q.mem_read;
   assign bus.ex_mem_write = ex_q.mem_write;
   assign bus.ex_illegal   = ex_q.illegal;
endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: decode/immediates, load-use bubble, backpressure, flush, reset.
// Regfile read data is modelled as a fixed tag plus the read address.
module tb_decode_issue;
   logic clk;
   logic rstb;
   int   passed;
   int   total;

   decode_issue_if bus ();

   decode_issue #(.XLEN(32), .HAZARD_EN(1'b1)) dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus.slave)
   );

   assign bus.rf_dataa = 32'hA000_0000 | 32'(bus.rf_addra);
   assign bus.rf_datab = 32'hB000_0000 | 32'(bus.rf_addrb);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      @(negedge clk);
      bus.if_valid = v;
      bus.if_instr = instr;
      bus.if_pc    = pc;
   endtask

   task automatic test_reset;
      rstb = 1'b0;
      bus.if_valid = 1'b1;
      bus.if_instr = 32'hFFD00293;
      bus.if_pc    = 32'h0000_0100;
      bus.ex_ready = 1'b1;
      bus.flush    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (bus.ex_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.ex_valid); else passed++;
      total++;
      if ({bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm, bus.ex_rs1, bus.ex_rs2, bus.ex_rd,
           bus.ex_opcode, bus.ex_funct3, bus.ex_funct7b5, bus.ex_reg_write, bus.ex_mem_read,
           bus.ex_mem_write, bus.ex_illegal} !== '0)
         $display("FAIL reset_fields: got pc=%h imm=%h rd=%0d op=%h want all zero", bus.ex_pc, bus.ex_imm, bus.ex_rd, bus.ex_opcode);
      else passed++;
      total++; if (bus.rf_addra !== 5'd0 || bus.rf_addrb !== 5'd29) $display("FAIL reset_rfaddr: got %0d/%0d want 0/29", bus.rf_addra, bus.rf_addrb); else passed++;
      @(negedge clk);
      rstb = 1'b1;
      @(posedge clk); #1;
      total++; if (bus.ex_valid !== 1'b1) $display("FAIL addi_valid: got %b want 1", bus.ex_valid); else passed++;
      total++; if (bus.ex_imm !== 32'hFFFF_FFFD) $display("FAIL addi_imm: got %h want fffffffd", bus.ex_imm); else passed++;
      total++; if (bus.ex_rd !== 5'd5 || bus.ex_reg_write !== 1'b1) $display("FAIL addi_rd: got rd=%0d rw=%b want 5/1", bus.ex_rd, bus.ex_reg_write); else passed++;
      total++; if (bus.ex_rs1_data !== 32'hA000_0000 || bus.ex_pc !== 32'h100) $display("FAIL addi_data: got %h pc=%h want a0000000 pc=100", bus.ex_rs1_data, bus.ex_pc); else passed++;
      drive(1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_immediates;
      drive(1'b1, 32'h0020A423, 32'h200);
      @(posedge clk); #1;
      total++; if (bus.ex_imm !== 32'd8) $display("FAIL sw_imm: got %h want 8", bus.ex_imm); else passed++;
      total++; if (bus.ex_mem_write !== 1'b1 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_read !== 1'b0) $display("FAIL sw_ctrl: got mw=%b rw=%b mr=%b want 1/0/0", bus.ex_mem_write, bus.ex_reg_write, bus.ex_mem_read); else passed++;
      total++; if (bus.ex_rs2_data !== 32'hB000_0002 || bus.ex_rs1 !== 5'd1 || bus.ex_funct3 !== 3'd2) $display("FAIL sw_fields: got rs2d=%h rs1=%0d f3=%0d want b0000002/1/2", bus.ex_rs2_data, bus.ex_rs1, bus.ex_funct3); else passed++;
      drive(1'b1, 32'hFE000EE3, 32'h204);
      @(posedge clk); #1;
      total++; if (bus.ex_imm !== 32'hFFFF_FFFC) $display("FAIL beq_imm: got %h want fffffffc", bus.ex_imm); else passed++;
      total++; if (bus.ex_reg_write !== 1'b0 || bus.ex_funct7b5 !== 1'b1) $display("FAIL beq_ctrl: got rw=%b f7b5=%b want 0/1", bus.ex_reg_write, bus.ex_funct7b5); else passed++;
      drive(1'b1, 32'h001000EF, 32'h208);
      @(posedge clk); #1;
      total++; if (bus.ex_imm !== 32'h0000_0800) $display("FAIL jal_imm: got %h want 00000800", bus.ex_imm); else passed++;
      total++; if (bus.ex_rd !== 5'd1 || bus.ex_reg_write !== 1'b1 || bus.ex_opcode !== 7'h6F) $display("FAIL jal_ctrl: got rd=%0d rw=%b op=%h want 1/1/6f", bus.ex_rd, bus.ex_reg_write, bus.ex_opcode); else passed++;
      drive(1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_load_use;
      drive(1'b1, 32'h0000A183, 32'h300);
      @(posedge clk); #1;
      total++; if (bus.ex_mem_read !== 1'b1 || bus.ex_rd !== 5'd3) $display("FAIL lw_ctrl: got mr=%b rd=%0d want 1/3", bus.ex_mem_read, bus.ex_rd); else passed++;
      drive(1'b1, 32'h00218233, 32'h304);
      #1;
      total++; if (bus.id_ready !== 1'b0) $display("FAIL lu_stall: got id_ready=%b want 0", bus.id_ready); else passed++;
      @(posedge clk); #1;
      total++; if (bus.ex_valid !== 1'b0) $display("FAIL lu_bubble: got ex_valid=%b want 0", bus.ex_valid); else passed++;
      total++; if (bus.id_ready !== 1'b1) $display("FAIL lu_release: got id_ready=%b want 1", bus.id_ready); else passed++;
      @(posedge clk); #1;
      total++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd4 || bus.ex_pc !== 32'h304) $display("FAIL lu_issue: got v=%b rd=%0d pc=%h want 1/4/304", bus.ex_valid, bus.ex_rd, bus.ex_pc); else passed++;
      total++; if (bus.ex_rs1_data !== 32'hA000_0003) $display("FAIL lu_rs1data: got %h want a0000003", bus.ex_rs1_data); else passed++;
      // Load to x0 never creates a dependency.
      drive(1'b1, 32'h0000A003, 32'h310);
      @(posedge clk); #1;
      drive(1'b1, 32'h00200233, 32'h314);
      #1;
      total++; if (bus.id_ready !== 1'b1) $display("FAIL lu_x0_nostall: got id_ready=%b want 1", bus.id_ready); else passed++;
      @(posedge clk); #1;
      total++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h314) $display("FAIL lu_x0_issue: got v=%b pc=%h want 1/314", bus.ex_valid, bus.ex_pc); else passed++;
      drive(1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_backpressure;
      drive(1'b1, 32'hFFD00293, 32'h400);
      @(posedge clk); #1;
      drive(1'b1, 32'h00208033, 32'h404);
      bus.ex_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (bus.id_ready !== 1'b0) $display("FAIL bp_ready_%0d: got %b want 0", i, bus.id_ready); else passed++;
         @(posedge clk); #1;
         total++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h400 || bus.ex_imm !== 32'hFFFF_FFFD) $display("FAIL bp_hold_%0d: got v=%b pc=%h imm=%h want 1/400/fffffffd", i, bus.ex_valid, bus.ex_pc, bus.ex_imm); else passed++;
         @(negedge clk);
      end
      bus.ex_ready = 1'b1;
      #1;
      total++; if (bus.id_ready !== 1'b1) $display("FAIL bp_resume: got id_ready=%b want 1", bus.id_ready); else passed++;
      @(posedge clk); #1;
      total++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h404) $display("FAIL bp_next: got v=%b pc=%h want 1/404", bus.ex_valid, bus.ex_pc); else passed++;
      total++; if (bus.ex_reg_write !== 1'b0 || bus.ex_rd !== 5'd0) $display("FAIL add_x0: got rw=%b rd=%0d want 0/0", bus.ex_reg_write, bus.ex_rd); else passed++;
      drive(1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_flush;
      drive(1'b1, 32'hFFD00293, 32'h500);
      @(posedge clk); #1;
      drive(1'b1, 32'h00218233, 32'h504);
      bus.ex_ready = 1'b0;
      bus.flush    = 1'b1;
      #1;
      total++; if (bus.id_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", bus.id_ready); else passed++;
      @(posedge clk); #1;
      total++; if (bus.ex_valid !== 1'b0) $display("FAIL flush_kill: got ex_valid=%b want 0", bus.ex_valid); else passed++;
      @(negedge clk);
      bus.flush    = 1'b0;
      bus.ex_ready = 1'b1;
      // Flush while a load-use hazard is pending.
      drive(1'b1, 32'h0000A183, 32'h510);
      @(posedge clk); #1;
      drive(1'b1, 32'h00218233, 32'h514);
      #1;
      total++; if (bus.id_ready !== 1'b0) $display("FAIL flush_hz_pre: got id_ready=%b want 0", bus.id_ready); else passed++;
      bus.flush = 1'b1;
      #1;
      total++; if (bus.id_ready !== 1'b1) $display("FAIL flush_hz_ready: got %b want 1", bus.id_ready); else passed++;
      @(posedge clk); #1;
      total++; if (bus.ex_valid !== 1'b0) $display("FAIL flush_hz_bubble: got ex_valid=%b want 0", bus.ex_valid); else passed++;
      @(negedge clk);
      bus.flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_illegal;
      drive(1'b1, 32'h0000007F, 32'h600);
      @(posedge clk); #1;
      total++; if (bus.ex_illegal !== 1'b1) $display("FAIL illegal_flag: got %b want 1", bus.ex_illegal); else passed++;
      total++; if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== 3'b000 || bus.ex_imm !== 32'h0) $display("FAIL illegal_ctrl: got ctrl=%b imm=%h want 000/0", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, bus.ex_imm); else passed++;
      drive(1'b1, 32'h00000073, 32'h604);
      @(posedge clk); #1;
      total++; if (bus.ex_illegal !== 1'b0 || bus.ex_valid !== 1'b1) $display("FAIL system_legal: got ill=%b v=%b want 0/1", bus.ex_illegal, bus.ex_valid); else passed++;
      drive(1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_async_reset_stall;
      drive(1'b1, 32'hFFD00293, 32'h700);
      @(posedge clk); #1;
      bus.ex_ready = 1'b0;
      @(negedge clk);
      #2;
      rstb = 1'b0;
      #1;
      total++; if (bus.ex_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", bus.ex_valid); else passed++;
      total++; if (bus.id_ready !== 1'b1) $display("FAIL arst_ready: got %b want 1", bus.id_ready); else passed++;
      @(negedge clk);
      rstb = 1'b1;
      bus.ex_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_immediates();
      test_load_use();
      test_backpressure();
      test_flush();
      test_illegal();
      test_async_reset_stall();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
